seven_segment_scanner: RTL

- Downstream display stage for the chronometer: consumes the four decoded seven-segment patterns and drives one shared segment bus plus four digit-enable lines.
- Time-multiplexes the digits at a programmable refresh rate, with an anti-ghosting blank gap at each digit change.
- Snapshots all four patterns once per frame so a displayed frame is always self-consistent; a HOLD input freezes the display for lap readout.

---
 rtl/seven_segment_scanner.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed four-digit seven-segment driver with a per-frame snapshot.
// Optional leading-zero suppression is compiled in when LEADING_ZERO_BLANK_EN is defined.
module seven_segment_scanner #(
    parameter int         REFRESH_DIV    = 50000,
    parameter int         BLANK_CYCLES   = 16,
    parameter bit         SEG_ACTIVE_LOW = 1'b1,
    parameter bit         AN_ACTIVE_LOW  = 1'b1,
    parameter logic [6:0] ZERO_PATTERN   = 7'b0111111
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       HOLD,
    input  logic [6:0] segment_digit_0,
    input  logic [6:0] segment_digit_1,
    input  logic [6:0] segment_digit_2,
    input  logic [6:0] segment_digit_3,
    output logic [6:0] SEG,
    output logic [3:0] AN,
    output logic [1:0] DIGIT_SEL,
    output logic       FRAME_START
);

    localparam int            PW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_LIM  = PW'(BLANK_CYCLES);
    localparam logic [6:0]    SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]    AN_OFF     = AN_ACTIVE_LOW ? 4'hF : 4'h0;

    function automatic logic [6:0] seg_drive(input logic [6:0] pattern);
        return SEG_ACTIVE_LOW ? ~pattern : pattern;
    endfunction

    function automatic logic [3:0] an_drive(input logic [1:0] sel);
        logic [3:0] onehot;
        onehot = 4'b0001 << sel;
        return AN_ACTIVE_LOW ? ~onehot : onehot;
    endfunction

    logic [PW-1:0] presc_r;
    logic [1:0]    idx_r;
    logic [6:0]    snap_r [4];
    logic [6:0]    seg_r;
    logic [3:0]    an_r;
    logic [1:0]    sel_r;
    logic          frame_start_r;

    logic          slot_end_s;
    logic          capture_s;
    logic          show_s;
    logic [3:0]    blank_mask_s;
    logic [6:0]    seg_next_s;
    logic [3:0]    an_next_s;

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:1] zero_s;
    assign zero_s[3] = (snap_r[3] == ZERO_PATTERN);
    assign zero_s[2] = (snap_r[2] == ZERO_PATTERN);
    assign zero_s[1] = (snap_r[1] == ZERO_PATTERN);
    // A digit is suppressed only if it and every digit to its left read zero.
    assign blank_mask_s = {zero_s[3],
                           zero_s[3] & zero_s[2],
                           zero_s[3] & zero_s[2] & zero_s[1],
                           1'b0};
`else
    logic unused_zero_pattern_s;
    assign unused_zero_pattern_s = ^ZERO_PATTERN;
    assign blank_mask_s          = 4'b0000;
`endif

    // Slot timing decisions and next-cycle output pattern.
    always_comb begin
        slot_end_s = EN && (presc_r == PRESC_LAST);
        capture_s  = slot_end_s && (idx_r == 2'd3) && !HOLD;
        show_s     = EN && (presc_r >= BLANK_LIM) && !blank_mask_s[idx_r];
        if (show_s) begin
            seg_next_s = seg_drive(snap_r[idx_r]);
            an_next_s  = an_drive(idx_r);
        end else begin
            seg_next_s = SEG_OFF;
            an_next_s  = AN_OFF;
        end
    end

    // Prescaler, digit index, frame snapshot and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_r       <= {PW{1'b0}};
            idx_r         <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                snap_r[i] <= 7'h00;
            end
            seg_r         <= SEG_OFF;
            an_r          <= AN_OFF;
            sel_r         <= 2'd0;
            frame_start_r <= 1'b0;
        end else begin
            if (EN) begin
                presc_r <= slot_end_s ? {PW{1'b0}} : presc_r + PW'(1);
                if (slot_end_s) begin
                    idx_r <= idx_r + 2'd1;
                end
            end
            // All four digits are latched together so a frame never mixes old and new values.
            if (capture_s) begin
                snap_r[0] <= segment_digit_0;
                snap_r[1] <= segment_digit_1;
                snap_r[2] <= segment_digit_2;
                snap_r[3] <= segment_digit_3;
            end
            seg_r         <= seg_next_s;
            an_r          <= an_next_s;
            sel_r         <= idx_r;
            frame_start_r <= capture_s;
        end
    end

    assign SEG         = seg_r;
    assign AN          = an_r;
    assign DIGIT_SEL   = sel_r;
    assign FRAME_START = frame_start_r;

endmodule
